// File: rtl/fabric_config_loader_if.sv
// -----------------------------------------------------------------------------
// fabric_config_loader_if
// Bundles the bitstream word stream and the frame write port of the
// configuration loader.
//   in_data/in_valid/in_ready : bitstream words, transfer on valid && ready
//   cfg_we/cfg_addr/cfg_data  : one-cycle frame write into the fabric
// Modports:
//   master : bitstream source / fabric side (drives words, observes writes)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface fabric_config_loader_if #(
  parameter int FRAME_W    = 33,
  parameter int NUM_FRAMES = 44,
  parameter int IN_W       = 8
);
  localparam int AW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic [IN_W-1:0]    in_data;
  logic               in_valid;
  logic               in_ready;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [FRAME_W-1:0] cfg_data;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  cfg_we,
    input  cfg_addr,
    input  cfg_data
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output cfg_we,
    output cfg_addr,
    output cfg_data
  );
endinterface

// File: rtl/fabric_config_loader.sv
// -----------------------------------------------------------------------------
// fabric_config_loader
// Streams a configuration bitstream into the fabric's frame registers.
// Each frame is assembled LSB-first from BPF input words, written by index,
// and after the last frame a trailing XOR checksum word is verified. The
// fabric enable is only raised after a load whose checksum matched.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   start     : one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   bus       : slave side of fabric_config_loader_if (word stream + frame write)
//   busy      : load in progress (LOAD/WRITE/CHECK)
//   done      : last load completed with a matching checksum
//   error     : last load completed with a checksum mismatch
//   fabric_en : fabric may run (only in DONE)
// -----------------------------------------------------------------------------
module fabric_config_loader #(
  parameter int FRAME_W    = 33,
  parameter int NUM_FRAMES = 44,
  parameter int IN_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  fabric_config_loader_if.slave   bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    fabric_en
);
  localparam int BPF   = (FRAME_W + IN_W - 1) / IN_W;
  localparam int AW    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int WW    = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int BUF_W = BPF * IN_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             r_state;
  logic [WW-1:0]      r_word;
  logic [AW-1:0]      r_frame_idx;
  logic [IN_W-1:0]    r_acc;
  logic [BUF_W-1:0]   r_frame;
  logic               r_cfg_we;
  logic [AW-1:0]      r_cfg_addr;
  logic [FRAME_W-1:0] r_cfg_data;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_fabric_en;

  logic               w_in_ready;
  logic               w_xfer;
  logic               w_last_word;
  logic               w_last_frame;
  logic [BUF_W-1:0]   w_frame_next;

  // Readiness depends on state only so the source never sees a
  // combinational path from its own valid back to ready.
  assign w_in_ready   = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_xfer       = bus.in_valid && w_in_ready;
  assign w_last_word  = (r_word == WW'(BPF - 1));
  assign w_last_frame = (r_frame_idx == AW'(NUM_FRAMES - 1));

  // Frame buffer with the current word merged in, so the final word of a
  // frame can be forwarded straight into cfg_data on the same edge.
  // The buffer is BPF words wide; bits above FRAME_W are never written out.
  genvar gi;
  generate
    for (gi = 0; gi < BPF; gi++) begin : g_slice
      assign w_frame_next[gi*IN_W +: IN_W] =
        (w_xfer && (r_state == S_LOAD) && (r_word == WW'(gi))) ?
        bus.in_data : r_frame[gi*IN_W +: IN_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_frame_idx <= '0;
      r_acc       <= '0;
      r_frame     <= '0;
      r_cfg_we    <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_fabric_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_word      <= '0;
            r_frame_idx <= '0;
            r_acc       <= '0;
            r_frame     <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_fabric_en <= 1'b0;
          end
        end

        S_LOAD: begin
          if (w_xfer) begin
            // Every bit of the word feeds the checksum, including bits
            // that fall beyond FRAME_W in the last word of a frame.
            r_acc   <= r_acc ^ bus.in_data;
            r_frame <= w_frame_next;
            if (w_last_word) begin
              r_word     <= '0;
              r_state    <= S_WRITE;
              r_cfg_we   <= 1'b1;
              r_cfg_addr <= r_frame_idx;
              r_cfg_data <= w_frame_next[FRAME_W-1:0];
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
        end

        S_WRITE: begin
          r_cfg_we <= 1'b0;
          r_frame  <= '0;
          if (w_last_frame) begin
            r_state <= S_CHECK;
          end else begin
            r_frame_idx <= r_frame_idx + 1'b1;
            r_state     <= S_LOAD;
          end
        end

        S_CHECK: begin
          if (w_xfer) begin
            r_busy <= 1'b0;
            if (bus.in_data == r_acc) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_fabric_en <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.cfg_we   = r_cfg_we;
  assign bus.cfg_addr = r_cfg_addr;
  assign bus.cfg_data = r_cfg_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign fabric_en    = r_fabric_en;
endmodule

// File: tb/tb_fabric_config_loader.sv
// -----------------------------------------------------------------------------
// tb_fabric_config_loader
// Directed scenarios for fabric_config_loader with FRAME_W=12, NUM_FRAMES=3,
// IN_W=8. Expected frame writes are queued when a frame's last word is driven
// and checked by a monitor when cfg_we fires.
// -----------------------------------------------------------------------------
module tb_fabric_config_loader;
  localparam int FRAME_W    = 12;
  localparam int NUM_FRAMES = 3;
  localparam int IN_W       = 8;

  typedef struct {
    logic [1:0]  addr;
    logic [11:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, error, fabric_en;

  int n_total = 0;
  int n_bad   = 0;
  bit exp_we  = 1'b0;
  wr_t wq[$];

  fabric_config_loader_if #(
    .FRAME_W(FRAME_W), .NUM_FRAMES(NUM_FRAMES), .IN_W(IN_W)
  ) bus ();

  fabric_config_loader #(
    .FRAME_W(FRAME_W), .NUM_FRAMES(NUM_FRAMES), .IN_W(IN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus.slave),
    .busy(busy),
    .done(done),
    .error(error),
    .fabric_en(fabric_en)
  );

  always #5 clk = ~clk;

  // Write monitor: checks cfg_we timing against the bench's expectation and
  // the written address/data against the scoreboard queue.
  always @(negedge clk) begin
    if (bus.cfg_we === 1'b1 || exp_we) begin
      n_total++;
      if (bus.cfg_we !== exp_we) begin
        n_bad++;
        $display("FAIL we_timing: cfg_we=%b required=%b", bus.cfg_we, exp_we);
      end
      exp_we = 1'b0;
    end
    if (bus.cfg_we === 1'b1) begin
      n_total++;
      if (bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ready_in_write: in_ready=%b required=0", bus.in_ready);
      end
      n_total++;
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h required=none", bus.cfg_addr, bus.cfg_data);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (bus.cfg_addr !== e.addr || bus.cfg_data !== e.data) begin
          n_bad++;
          $display("FAIL frame_write: addr=%0d data=%h required addr=%0d data=%h",
                   bus.cfg_addr, bus.cfg_data, e.addr, e.data);
        end else begin
          $display("write addr=%0d data=%h ok", bus.cfg_addr, bus.cfg_data);
        end
      end
    end
  end

  // Drive one word and return just after the edge that accepted it.
  task automatic send(input logic [7:0] b, input bit last_of_frame, input bit mid_start);
    int waits = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    start        = mid_start;
    while (bus.in_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      start = 1'b0;
      waits++;
    end
    if (waits >= 100) begin
      n_total++;
      n_bad++;
      $display("FAIL ready_timeout: in_ready=%b required=1 within 100 cycles", bus.in_ready);
    end
    @(posedge clk);
    if (last_of_frame) exp_we = 1'b1;
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      start        = 1'b0;
      n_total++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_in_stall: busy=%b required=1", busy);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Six frame words then the checksum word.
  task automatic run_stream(input logic [7:0] w[7], input bit stalls, input bit mid_start);
    for (int i = 0; i < 6; i++) begin
      if (stalls && i == 2) stall(5);
      if (i % 2 == 1) begin
        wr_t e;
        logic [15:0] pair;
        pair   = {w[i], w[i-1]};
        e.addr = 2'(i / 2);
        e.data = pair[11:0];
        wq.push_back(e);
      end
      send(w[i], (i % 2 == 1), (mid_start && i == 3));
    end
    if (stalls) stall(5);
    send(w[6], 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] xor6(input logic [7:0] w[7]);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 6; i++) x ^= w[i];
    return x;
  endfunction

  task automatic check_result(input string name, input logic exp_ok);
    @(negedge clk);
    bus.in_valid = 1'b0;
    start        = 1'b0;
    n_total += 5;
    if (done !== exp_ok) begin
      n_bad++; $display("FAIL %s_done: done=%b required=%b", name, done, exp_ok);
    end
    if (error !== !exp_ok) begin
      n_bad++; $display("FAIL %s_error: error=%b required=%b", name, error, !exp_ok);
    end
    if (fabric_en !== exp_ok) begin
      n_bad++; $display("FAIL %s_fabric_en: fabric_en=%b required=%b", name, fabric_en, exp_ok);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_busy: busy=%b required=0", name, busy);
    end
    if (wq.size() != 0) begin
      n_bad++; $display("FAIL %s_missing_writes: pending=%0d required=0", name, wq.size());
    end
    $display("%s: done=%b error=%b fabric_en=%b", name, done, error, fabric_en);
  endtask

  logic [7:0] w_clean[7];
  logic [7:0] w_bad[7];
  logic [7:0] w_trunc[7];

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    @(negedge clk);
    @(negedge clk);
    n_total += 8;
    if (busy !== 1'b0)          begin n_bad++; $display("FAIL reset_busy: busy=%b required=0", busy); end
    if (done !== 1'b0)          begin n_bad++; $display("FAIL reset_done: done=%b required=0", done); end
    if (error !== 1'b0)         begin n_bad++; $display("FAIL reset_error: error=%b required=0", error); end
    if (fabric_en !== 1'b0)     begin n_bad++; $display("FAIL reset_fabric_en: fabric_en=%b required=0", fabric_en); end
    if (bus.in_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_in_ready: in_ready=%b required=0", bus.in_ready); end
    if (bus.cfg_we !== 1'b0)    begin n_bad++; $display("FAIL reset_cfg_we: cfg_we=%b required=0", bus.cfg_we); end
    if (bus.cfg_addr !== 2'd0)  begin n_bad++; $display("FAIL reset_cfg_addr: cfg_addr=%0d required=0", bus.cfg_addr); end
    if (bus.cfg_data !== 12'h0) begin n_bad++; $display("FAIL reset_cfg_data: cfg_data=%h required=000", bus.cfg_data); end
    rst = 1'b0;
    $display("reset: checked");
  endtask

  task automatic test_clean_load();
    pulse_start();
    run_stream(w_clean, 1'b0, 1'b0);
    check_result("clean", (w_clean[6] == xor6(w_clean)));
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    run_stream(w_bad, 1'b0, 1'b0);
    check_result("bad_checksum", (w_bad[6] == xor6(w_bad)));
  endtask

  task automatic test_stalls();
    pulse_start();
    run_stream(w_clean, 1'b1, 1'b0);
    check_result("stalls", 1'b1);
  endtask

  task automatic test_reset_mid_load();
    wr_t e;
    pulse_start();
    e.addr = 2'd0;
    e.data = 12'h0A5;
    wq.push_back(e);
    send(8'hA5, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'hC1, 1'b0, 1'b0);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_total += 3;
    if (busy !== 1'b0)         begin n_bad++; $display("FAIL midrst_busy: busy=%b required=0", busy); end
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready: in_ready=%b required=0", bus.in_ready); end
    if (fabric_en !== 1'b0)    begin n_bad++; $display("FAIL midrst_fabric_en: fabric_en=%b required=0", fabric_en); end
    repeat (4) @(negedge clk);
    $display("reset_mid_load: aborted");
    pulse_start();
    run_stream(w_clean, 1'b0, 1'b0);
    check_result("after_reset", 1'b1);
  endtask

  task automatic test_restart();
    pulse_start();
    n_total += 3;
    if (done !== 1'b0)      begin n_bad++; $display("FAIL restart_done: done=%b required=0", done); end
    if (fabric_en !== 1'b0) begin n_bad++; $display("FAIL restart_fabric_en: fabric_en=%b required=0", fabric_en); end
    if (busy !== 1'b1)      begin n_bad++; $display("FAIL restart_busy: busy=%b required=1", busy); end
    $display("restart: fabric disabled");
    run_stream(w_clean, 1'b0, 1'b1);
    check_result("restart_ignored_start", 1'b1);
  endtask

  task automatic test_truncated();
    pulse_start();
    run_stream(w_trunc, 1'b0, 1'b0);
    check_result("truncated", (w_trunc[6] == xor6(w_trunc)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    w_clean = '{8'hA5, 8'h00, 8'hC1, 8'h03, 8'hFF, 8'h0F, 8'h97};
    w_bad   = '{8'hA5, 8'h00, 8'hC1, 8'h03, 8'hFF, 8'h0F, 8'h96};
    w_trunc = '{8'hA5, 8'hF0, 8'hC1, 8'h03, 8'hFF, 8'h0F, 8'h67};
    test_reset();
    test_clean_load();
    test_bad_checksum();
    test_stalls();
    test_reset_mid_load();
    test_restart();
    test_truncated();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Streams a configuration bitstream into the configurable fabric's frame registers (LUT contents, switch-box and output-box configure words) over a valid/ready word interface.
- Assembles each frame from input words, writes it by address, then verifies a trailing XOR checksum.
- Holds the fabric disabled until a load completes cleanly.
- Replaces per-instance hierarchical configuration with a parametrised, self-checking loader sized for any fabric width or depth.

Parameters:
- FRAME_W, 33: bits per configuration frame.
- NUM_FRAMES, 44: frames per bitstream.
- IN_W, 8: input word width.
- Derived, not overridable:
  - BPF = ceil(FRAME_W/IN_W), words per frame.
  - AW = max(1, clog2(NUM_FRAMES)).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- start  in  1  begin a load; one-cycle pulse.
- in_data  in  IN_W  bitstream word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- cfg_we  out  1  frame write strobe.
- cfg_addr  out  AW  frame index being written.
- cfg_data  out  FRAME_W  assembled frame.
- busy  out  1  load in progress.
- done  out  1  load completed, checksum matched.
- error  out  1  load completed, checksum mismatch.
- fabric_en  out  1  fabric may run; high only in DONE.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- rst result: IDLE state; frame/word counters and XOR accumulator cleared; all outputs 0 (including cfg_data and cfg_addr).
- Transfer rule: a word transfers when in_valid && in_ready. in_ready is combinational from state only (never from in_valid).
- States:
  - IDLE: in_ready=0. start -> LOAD.
  - LOAD: in_ready=1, busy=1.
    - Each transfer stores the word into frame slice [w*IN_W +: IN_W], LSB-first (w = word count within frame), and XORs it into the accumulator.
    - Bits of the last word beyond FRAME_W are dropped from the frame but still XORed.
    - After the BPF-th transfer -> WRITE.
  - WRITE: one cycle; in_ready=0, busy=1.
    - cfg_we=1, cfg_addr=frame index, cfg_data=assembled frame.
    - Next: if frame index==NUM_FRAMES-1 -> CHECK; else increment index, clear the frame buffer -> LOAD.
  - CHECK: in_ready=1, busy=1.
    - On transfer: word==accumulator -> DONE; else -> ERROR.
    - The checksum word is not XORed into the accumulator.
  - DONE: done=1, fabric_en=1.
  - ERROR: error=1, fabric_en=0.
  - In DONE or ERROR, start -> LOAD and clears done, error, counters and accumulator on the same edge.
- Latency: cfg_we is registered and asserted the cycle after the last word of a frame is accepted. done/error are asserted the cycle after the checksum word is accepted.
- Throughput: one word per cycle, plus exactly one bubble per frame (the WRITE cycle).
- cfg_we is high only in WRITE. cfg_data and cfg_addr hold their last values otherwise.
- start is ignored in LOAD, WRITE and CHECK; no restart mid-load.
- in_valid low stalls the load indefinitely with no state change.
- rst mid-load: abort to IDLE. Frames already written stay in the fabric; fabric_en remains 0 until a subsequent clean load.
- Any start from DONE drops fabric_en on the next cycle (reconfiguration disables the fabric).
- NUM_FRAMES=1 and BPF=1 must work. WRITE always follows every frame.

Test Plan:
Parameters for all directed tests: FRAME_W=12, NUM_FRAMES=3, IN_W=8 (BPF=2).
1. Clean load:
   - Stimulus: rst 1 cycle, start, then words A5,00,C1,03,FF,0F,97 with in_valid held high.
   - Required: cfg_we pulses write (addr0,0x0A5), (addr1,0x3C1), (addr2,0xFFF), each one cycle after the frame's second word; in_ready low in those cycles.
   - Required: done=1 and fabric_en=1 one cycle after 97 is accepted; error=0.
2. Bad checksum:
   - Stimulus: same stream with last word 96.
   - Required: same three writes, then error=1, done=0, fabric_en=0.
3. Stalls:
   - Stimulus: in_valid deasserted for 5 cycles between words 2 and 3, and again before the checksum.
   - Required: identical writes and done; busy stays 1 throughout.
4. Reset mid-load:
   - Stimulus: rst asserted after word C1.
   - Required: next cycle busy=0, in_ready=0, fabric_en=0, no further cfg_we.
   - Then a fresh start plus scenario-1 stream -> done=1.
5. Restart from DONE / ignored start:
   - Stimulus: after scenario 1, pulse start.
   - Required: done and fabric_en fall on the next cycle and the loader accepts a new stream.
   - Stimulus: start pulsed during LOAD.
   - Required: no effect on counters, writes, or final result.
6. Truncated last-word bits:
   - Stimulus: frame-0 words A5,F0 (upper nibble set), with checksum recomputed to 0x67.
   - Required: cfg_data for addr0 = 0x0A5; done=1.
